// File: rtl/pong_fb_writer.sv
// Pong frame-buffer writer: on each frame_done edge, repaints every
// tile of the frame buffer with background, ball and paddle colours.
module pong_fb_writer #(
  parameter int GRID_W  = 160,
  parameter int GRID_H  = 120,
  parameter int PAD_H   = 16,
  parameter int PAD_XL  = 4,
  parameter int PAD_XR  = 155,
  parameter int BALL_SZ = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_done,
  input  logic        mem_grant,
  input  logic [7:0]  ball_x,
  input  logic [6:0]  ball_y,
  input  logic [6:0]  lpad_y,
  input  logic [6:0]  rpad_y,
  input  logic [23:0] fg_color,
  input  logic [23:0] bg_color,
  output logic [14:0] fb_address,
  output logic [23:0] fb_data,
  output logic        fb_wren,
  output logic        busy,
  output logic        done,
  output logic        overrun
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LATCH,
    S_WRITE,
    S_DONE
  } state_e;

  localparam logic [14:0] LAST = 15'(GRID_W * GRID_H - 1);

  state_e      state_q, state_d;
  logic        fd_q;
  logic        rise;
  logic [7:0]  col_q, col_d;
  logic [6:0]  row_q, row_d;
  logic [14:0] addr_q, addr_d;
  logic [7:0]  bx_q;
  logic [6:0]  by_q, lp_q, rp_q;
  logic [23:0] fg_q, bg_q;
  logic [14:0] fba_d;
  logic [23:0] fbd_d;
  logic        wren_d, done_d;
  logic        ovr_d;
  logic [8:0]  c9, r9;
  logic        in_ball, in_lpad, in_rpad;
  logic        last_tile;

  assign rise      = frame_done & ~fd_q;
  assign busy      = (state_q == S_LATCH) || (state_q == S_WRITE);
  assign last_tile = addr_q == LAST;

  // Nine-bit extents so objects past the last row/column clip, not wrap
  always_comb begin
    c9 = {1'b0, col_q};
    r9 = {2'b0, row_q};
    in_ball = (c9 >= {1'b0, bx_q})
           && (c9 <= {1'b0, bx_q} + 9'(BALL_SZ - 1))
           && (r9 >= {2'b0, by_q})
           && (r9 <= {2'b0, by_q} + 9'(BALL_SZ - 1));
    in_lpad = (c9 == 9'(PAD_XL))
           && (r9 >= {2'b0, lp_q})
           && (r9 <= {2'b0, lp_q} + 9'(PAD_H - 1));
    in_rpad = (c9 == 9'(PAD_XR))
           && (r9 >= {2'b0, rp_q})
           && (r9 <= {2'b0, rp_q} + 9'(PAD_H - 1));
  end

  // State, edge detect, counters and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      fd_q       <= 1'b0;
      col_q      <= '0;
      row_q      <= '0;
      addr_q     <= '0;
      fb_address <= '0;
      fb_data    <= '0;
      fb_wren    <= 1'b0;
      done       <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      state_q    <= state_d;
      fd_q       <= frame_done;
      col_q      <= col_d;
      row_q      <= row_d;
      addr_q     <= addr_d;
      fb_address <= fba_d;
      fb_data    <= fbd_d;
      fb_wren    <= wren_d;
      done       <= done_d;
      overrun    <= ovr_d;
    end
  end

  // Scene snapshot taken in LATCH; held for the whole pass
  always_ff @(posedge clk) begin
    if (rst) begin
      bx_q <= '0;
      by_q <= '0;
      lp_q <= '0;
      rp_q <= '0;
      fg_q <= '0;
      bg_q <= '0;
    end else if (state_q == S_LATCH) begin
      bx_q <= ball_x;
      by_q <= ball_y;
      lp_q <= lpad_y;
      rp_q <= rpad_y;
      fg_q <= fg_color;
      bg_q <= bg_color;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (rise) state_d = S_LATCH;
      S_LATCH: state_d = S_WRITE;
      S_WRITE: if (mem_grant && last_tile) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output and counter logic
  always_comb begin
    col_d  = col_q;
    row_d  = row_q;
    addr_d = addr_q;
    fba_d  = fb_address;
    fbd_d  = fb_data;
    wren_d = 1'b0;
    done_d = 1'b0;
    ovr_d  = overrun | (rise && (state_q != S_IDLE));
    unique case (state_q)
      S_LATCH: begin
        col_d  = '0;
        row_d  = '0;
        addr_d = '0;
      end
      S_WRITE: begin
        if (mem_grant) begin
          wren_d = 1'b1;
          fba_d  = addr_q;
          fbd_d  = (in_ball || in_lpad || in_rpad) ? fg_q : bg_q;
          addr_d = addr_q + 15'd1;
          if (col_q == 8'(GRID_W - 1)) begin
            col_d = '0;
            row_d = row_q + 7'd1;
          end else begin
            col_d = col_q + 8'd1;
          end
        end
      end
      S_DONE:  done_d = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_pong_fb_writer.sv
// Scoreboard bench for pong_fb_writer: expected tile words are queued
// at each trigger and popped as write strobes appear.
module tb_pong_fb_writer;

  localparam int GW = 160;
  localparam int GH = 120;
  localparam int NT = GW * GH;

  logic        clk = 1'b0;
  logic        rst;
  logic        frame_done;
  logic        mem_grant;
  logic [7:0]  ball_x;
  logic [6:0]  ball_y, lpad_y, rpad_y;
  logic [23:0] fg_color, bg_color;
  logic [14:0] fb_address;
  logic [23:0] fb_data;
  logic        fb_wren, busy, done, overrun;

  int n_pass = 0;
  int n_chk  = 0;
  logic [38:0] sb_q[$];
  int strb_cnt = 0;
  int done_cnt = 0;
  int fg_cnt   = 0;
  logic [23:0] pass_fg;
  logic g_prev = 1'b0;
  bit tog = 1'b0;

  pong_fb_writer dut (
    .clk        (clk),
    .rst        (rst),
    .frame_done (frame_done),
    .mem_grant  (mem_grant),
    .ball_x     (ball_x),
    .ball_y     (ball_y),
    .lpad_y     (lpad_y),
    .rpad_y     (rpad_y),
    .fg_color   (fg_color),
    .bg_color   (bg_color),
    .fb_address (fb_address),
    .fb_data    (fb_data),
    .fb_wren    (fb_wren),
    .busy       (busy),
    .done       (done),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  function automatic bit is_fg(int r, int c, int bx, int by,
                               int lp, int rp);
    bit b;
    b = (c >= bx && c <= bx + 1 && r >= by && r <= by + 1);
    b = b || (c == 4 && r >= lp && r <= lp + 15);
    b = b || (c == 155 && r >= rp && r <= rp + 15);
    return b;
  endfunction

  always @(posedge clk) g_prev <= mem_grant;

  always @(negedge clk) begin
    if (fb_wren) begin
      strb_cnt++;
      if (fb_data == pass_fg) fg_cnt++;
      chk("grant_at_strobe", 64'(g_prev), 64'd1);
      if (sb_q.size() == 0) begin
        chk("unexpected_strobe", 64'(fb_address), 64'hFFFF);
      end else begin
        logic [38:0] e;
        e = sb_q.pop_front();
        chk("tile", 64'({fb_address, fb_data}), 64'(e));
      end
    end
    if (done) begin
      done_cnt++;
      chk("done_wren", 64'(fb_wren), 64'd0);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_pass();
    for (int r = 0; r < GH; r++)
      for (int c = 0; c < GW; c++)
        sb_q.push_back({15'(r * GW + c),
          is_fg(r, c, int'(ball_x), int'(ball_y),
                int'(lpad_y), int'(rpad_y)) ? fg_color : bg_color});
    pass_fg  = fg_color;
    strb_cnt = 0;
    fg_cnt   = 0;
    done_cnt = 0;
  endtask

  task automatic trigger(input bit hold);
    push_pass();
    frame_done = 1'b1;
    step();
    chk("latch_busy", 64'(busy), 64'd1);
    chk("no_early_wren", 64'(fb_wren), 64'd0);
    if (!hold) begin
      step();
      frame_done = 1'b0;
    end
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin
      step();
      if (tog) mem_grant = (n % 3 != 2);
      n++;
    end
    chk("done_timeout", 64'(done_cnt != 0), 64'd1);
    mem_grant = 1'b1;
    step();
    step();
  endtask

  task automatic wait_strobes(input int target, input int budget);
    int n = 0;
    while (strb_cnt < target && n < budget) begin
      @(posedge clk);
      n++;
    end
    chk("strobe_timeout", 64'(strb_cnt >= target), 64'd1);
    #1;
  endtask

  task automatic end_pass(input int fgs);
    chk("strobe_count", 64'(strb_cnt), 64'(NT));
    chk("sb_empty", 64'(sb_q.size()), 64'd0);
    chk("done_count", 64'(done_cnt), 64'd1);
    chk("fg_count", 64'(fgs), 64'(fg_cnt));
    chk("idle_busy", 64'(busy), 64'd0);
  endtask

  initial begin
    rst        = 1'b1;
    frame_done = 1'b0;
    mem_grant  = 1'b1;
    ball_x     = 8'd10;
    ball_y     = 7'd20;
    lpad_y     = 7'd50;
    rpad_y     = 7'd60;
    fg_color   = 24'hFFFFFF;
    bg_color   = 24'h000000;
    pass_fg    = 24'hFFFFFF;
    step();
    step();
    chk("rst_addr", 64'(fb_address), 64'd0);
    chk("rst_data", 64'(fb_data), 64'd0);
    chk("rst_ctl", 64'({fb_wren, busy, done, overrun}), 64'd0);
    rst = 1'b0;
    step();

    // basic pass, grant always high
    trigger(1'b0);
    wait_done(NT + 100);
    end_pass(36);
    chk("ovr_clear", 64'(overrun), 64'd0);

    // same scene with a stalling memory port
    tog = 1'b1;
    trigger(1'b0);
    wait_done(2 * NT);
    tog = 1'b0;
    end_pass(36);

    // overrun mid-pass and scene change after latch
    fg_color = 24'h12AB34;
    bg_color = 24'h0000C0;
    trigger(1'b0);
    wait_strobes(5000, NT);
    frame_done = 1'b1;
    ball_x     = 8'd80;
    ball_y     = 7'd60;
    lpad_y     = 7'd0;
    fg_color   = 24'h00FF00;
    bg_color   = 24'h555555;
    step();
    chk("overrun_set", 64'(overrun), 64'd1);
    wait_done(NT);
    end_pass(36);
    repeat (40) step();
    chk("no_restart", 64'(strb_cnt), 64'(NT));
    chk("overrun_sticky", 64'(overrun), 64'd1);
    frame_done = 1'b0;
    step();

    // abort by reset mid-pass
    ball_x   = 8'd159;
    ball_y   = 7'd119;
    lpad_y   = 7'd100;
    rpad_y   = 7'd110;
    fg_color = 24'hF0F0F0;
    bg_color = 24'h0F0F0F;
    trigger(1'b0);
    wait_strobes(1000, NT);
    rst = 1'b1;
    step();
    chk("abort_ctl", 64'({fb_wren, busy, overrun}), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    rst = 1'b0;
    sb_q.delete();
    strb_cnt = 0;
    repeat (30) step();
    chk("abort_quiet", 64'(strb_cnt + done_cnt), 64'd0);

    // restart from address 0 with clipped corner objects
    trigger(1'b0);
    wait_done(NT + 100);
    end_pass(27);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
